mem_reduce_top: RTL

Parametrised memory-reduction engine with an embedded dual-port RAM. A host fills the RAM through a wide word port. A Go/Done core then streams a programmable byte window (start address, length, address wrap) through one of four reduction modes: sum, max, min or match-count. The block replaces the fixed 8-bit/32-bit, sum-only core-plus-SRAM top used in the current design.

---
 rtl/mem_reduce_top_if.sv | 32 +++
 rtl/mem_reduce_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_reduce_top_if.sv
// Bus bundle for mem_reduce_top: Go/Done run control plus the wide host RAM port.
interface mem_reduce_top_if #(
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 8,
    parameter int HOST_WIDTH = 32,
    parameter int HA_WIDTH   = 6,
    parameter int R_WIDTH    = 20
);
    logic                  go;
    logic [A_WIDTH-1:0]    startAddr;
    logic [A_WIDTH:0]      length;
    logic [1:0]            mode;
    logic [D_WIDTH-1:0]    key;
    logic                  busy;
    logic                  done;
    logic [R_WIDTH-1:0]    result;
    logic                  hEn;
    logic                  hWe;
    logic [HA_WIDTH-1:0]   hAddr;
    logic [HOST_WIDTH-1:0] hDi;
    logic [HOST_WIDTH-1:0] hDo;

    modport master (
        output go, startAddr, length, mode, key, hEn, hWe, hAddr, hDi,
        input  busy, done, result, hDo
    );

    modport slave (
        input  go, startAddr, length, mode, key, hEn, hWe, hAddr, hDi,
        output busy, done, result, hDo
    );
endinterface

// File: rtl/mem_reduce_top.sv
// Memory-reduction engine: banked dual-port RAM filled by a wide host port, and a
// Go/Done core that folds a wrapping element window by sum, max, min or match-count.
module mem_reduce_top #(
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 8,
    parameter int HOST_WIDTH = 32,
    parameter int HA_WIDTH   = 6,
    parameter int R_WIDTH    = 20
) (
    input  logic            clk,
    input  logic            rst,
    mem_reduce_top_if.slave bus
);
    localparam int RATIO = HOST_WIDTH / D_WIDTH;
    localparam int LOG_R = $clog2(RATIO);
    localparam int SEL_W = (LOG_R > 0) ? LOG_R : 1;
    localparam int ROWS  = 1 << HA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state;
    logic [A_WIDTH-1:0]  r_addr;
    logic [A_WIDTH:0]    r_remain;
    logic                r_rdValid;
    logic                r_rdLast;
    logic                r_first;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_mode;
    logic [D_WIDTH-1:0]  r_key;
    logic [R_WIDTH-1:0]  r_acc;
    logic [R_WIDTH-1:0]  r_result;
    logic [SEL_W-1:0]    r_rdSel;

    logic [HA_WIDTH-1:0] w_hostRow;
    logic [HA_WIDTH-1:0] w_coreRow;
    logic [SEL_W-1:0]    w_coreSel;
    wire  [HOST_WIDTH-1:0] w_hDo;
    wire  [D_WIDTH-1:0]  w_cRd [RATIO];
    logic [D_WIDTH-1:0]  w_rdData;
    logic [R_WIDTH-1:0]  w_elem;
    logic [R_WIDTH-1:0]  w_fold;
    logic [R_WIDTH:0]    w_sum;

    assign w_hostRow = bus.hAddr;
    assign w_coreRow = HA_WIDTH'(r_addr >> LOG_R);
    assign w_coreSel = SEL_W'(int'(r_addr) % RATIO);

    // One bank per host-word slice, so a host write touches every bank at the same row
    // while the core reads a single element; reads before writes give old-data collisions.
    for (genvar k = 0; k < RATIO; k++) begin : g_bank
        logic [D_WIDTH-1:0] r_mem [ROWS];
        logic [D_WIDTH-1:0] r_hRd;
        logic [D_WIDTH-1:0] r_cRd;

        always_ff @(posedge clk) begin
            if (bus.hEn && bus.hWe) begin
                r_mem[w_hostRow] <= bus.hDi[k*D_WIDTH +: D_WIDTH];
            end
            r_cRd <= r_mem[w_coreRow];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hRd <= '0;
            end else if (bus.hEn && !bus.hWe) begin
                r_hRd <= r_mem[w_hostRow];
            end
        end

        assign w_hDo[k*D_WIDTH +: D_WIDTH] = r_hRd;
        assign w_cRd[k] = r_cRd;
    end

    always_ff @(posedge clk) begin
        r_rdSel <= w_coreSel;
    end

    assign w_rdData = w_cRd[r_rdSel];

    always_comb begin
        w_elem = R_WIDTH'(w_rdData);
        w_sum  = {1'b0, r_acc} + {1'b0, w_elem};
        w_fold = r_acc;
        case (r_mode)
            2'b00:   w_fold = w_sum[R_WIDTH] ? '1 : w_sum[R_WIDTH-1:0];
            2'b01:   if (r_first || w_elem > r_acc) w_fold = w_elem;
            2'b10:   if (r_first || w_elem < r_acc) w_fold = w_elem;
            default: if (w_rdData == r_key && r_acc != '1) w_fold = r_acc + R_WIDTH'(1);
        endcase
    end

    // Reads issue one per RUN cycle; r_rdValid/r_rdLast trail them by one cycle so the
    // fold lines up with the returning RAM data and the last fold publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_remain  <= '0;
            r_rdValid <= 1'b0;
            r_rdLast  <= 1'b0;
            r_first   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mode    <= '0;
            r_key     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        r_addr    <= bus.startAddr;
                        r_remain  <= bus.length;
                        r_mode    <= bus.mode;
                        r_key     <= bus.key;
                        r_acc     <= '0;
                        r_first   <= 1'b1;
                        r_rdValid <= 1'b0;
                        r_rdLast  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (r_remain != '0) begin
                        r_addr   <= r_addr + A_WIDTH'(1);
                        r_remain <= r_remain - (A_WIDTH+1)'(1);
                    end
                    r_rdValid <= (r_remain != '0);
                    r_rdLast  <= (r_remain == (A_WIDTH+1)'(1));
                    if (r_rdValid) begin
                        r_acc   <= w_fold;
                        r_first <= 1'b0;
                        if (r_rdLast) begin
                            r_result <= w_fold;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end else if (r_remain == '0) begin
                        r_result <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.hDo    = w_hDo;
endmodule
